// File: rtl/mem_arbiter_pkg.sv
// mem_arb_types: shared types for the memory arbiter slice.
//   arb_state_t : IDLE / BUSY transaction state
//   arb_op_t    : latched downstream operation (read or write)
//   wrap_inc    : modulo-n increment used for the round-robin pointer
package mem_arb_types;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;
  typedef enum logic {ARB_READ = 1'b0, ARB_WRITE = 1'b1} arb_op_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the upstream channel bus and the downstream
// memory port of mem_arbiter.
//   slave  : arbiter view (takes channel requests and mem_resp/mem_rdata,
//            drives ch_resp/ch_rdata and the mem_* request)
//   master : environment view (requesters + memory), the mirror image
// Per-channel fields are flat vectors; channel i lives at [i*W +: W].
interface mem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            ch_read;
  logic [NUM_PORTS-1:0]            ch_write;
  logic [NUM_PORTS*BE_WIDTH-1:0]   ch_byte_enable;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] ch_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] ch_wdata;
  logic [NUM_PORTS-1:0]            ch_resp;
  logic [DATA_WIDTH-1:0]           ch_rdata;

  logic                            mem_read;
  logic                            mem_write;
  logic [BE_WIDTH-1:0]             mem_byte_enable;
  logic [ADDR_WIDTH-1:0]           mem_address;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic                            mem_resp;
  logic [DATA_WIDTH-1:0]           mem_rdata;

  modport slave (
    input  ch_read, ch_write, ch_byte_enable, ch_address, ch_wdata,
    input  mem_resp, mem_rdata,
    output ch_resp, ch_rdata,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

  modport master (
    output ch_read, ch_write, ch_byte_enable, ch_address, ch_wdata,
    output mem_resp, mem_rdata,
    input  ch_resp, ch_rdata,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : per-channel request vector
//   ptr   : highest-priority channel this round
//   valid : any request present
//   idx   : first requester at or after ptr, wrapping modulo NUM_PORTS
module rr_pick #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic                         valid,
  output logic [$clog2(NUM_PORTS)-1:0] idx
);
  localparam int IDXW = $clog2(NUM_PORTS);

  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic [IDXW:0]          off;
  logic [IDXW:0]          sum;

  always_comb begin
    // Doubling the vector lets a plain right shift act as a rotation.
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_PORTS-1:0];
    off   = '0;
    valid = 1'b0;
    // Descending scan so the lowest set bit wins.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = (IDXW+1)'(i);
        valid = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IDXW+1)'(NUM_PORTS)) sum = sum - (IDXW+1)'(NUM_PORTS);
    idx = sum[IDXW-1:0];
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin N-channel arbiter onto one memory port, one
// transaction outstanding.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mem_arbiter_if.slave (channel requests in, ch_resp/ch_rdata out,
//          mem_* request out, mem_resp/mem_rdata in)
// The winner's op/address/data/byte-enables are latched on grant so the
// downstream request stays stable even if the requester changes or drops
// its inputs. ch_resp and ch_rdata are combinational from mem_resp.
module mem_arbiter
  import mem_arb_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDXW     = $clog2(NUM_PORTS);

  arb_state_t             state, state_nxt;
  arb_op_t                op;
  logic [IDXW-1:0]        rr_ptr, grant, pick_idx;
  logic                   pick_valid;
  logic [NUM_PORTS-1:0]   req;
  logic [ADDR_WIDTH-1:0]  lat_addr;
  logic [DATA_WIDTH-1:0]  lat_wdata;
  logic [BE_WIDTH-1:0]    lat_be;
  logic                   busy_rd, busy_wr;
  logic [NUM_PORTS-1:0]   resp_vec;

  assign req = bus.ch_read | bus.ch_write;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_valid)   state_nxt = BUSY;
      BUSY: if (bus.mem_resp) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Grant capture and round-robin pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant     <= '0;
      rr_ptr    <= '0;
      op        <= ARB_READ;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (state == IDLE && pick_valid) begin
      grant     <= pick_idx;
      // Read+write together is illegal; write wins.
      op        <= bus.ch_write[pick_idx] ? ARB_WRITE : ARB_READ;
      lat_addr  <= bus.ch_address[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
      lat_wdata <= bus.ch_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
      lat_be    <= bus.ch_byte_enable[pick_idx*BE_WIDTH +: BE_WIDTH];
    end else if (state == BUSY && bus.mem_resp) begin
      rr_ptr    <= IDXW'(wrap_inc(32'(grant), NUM_PORTS));
    end
  end

  // Outputs
  always_comb begin
    busy_rd  = 1'b0;
    busy_wr  = 1'b0;
    resp_vec = '0;
    if (state == BUSY) begin
      busy_rd = (op == ARB_READ);
      busy_wr = (op == ARB_WRITE);
      if (bus.mem_resp) resp_vec[grant] = 1'b1;
    end
  end

  assign bus.mem_read        = busy_rd;
  assign bus.mem_write       = busy_wr;
  assign bus.mem_address     = lat_addr;
  assign bus.mem_wdata       = lat_wdata;
  assign bus.mem_byte_enable = lat_be;
  assign bus.ch_resp         = resp_vec;
  assign bus.ch_rdata        = bus.mem_rdata;

  always @(posedge clk) begin
    if (rst) begin
      assert (!(|(bus.ch_read & bus.ch_write)));
      assert ($onehot0(resp_vec));
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel arbiter that multiplexes several requesters onto one downstream memory port.
- Requesters are typically the I-cache and D-cache of the pipelined core, plus optional prefetch or DMA ports.
- Upstream and downstream sides both use the core's existing memory handshake: read/write level request, held until a single-cycle resp.
- Arbitration is round-robin with one outstanding transaction; the previous single-port CPU top had no arbitration at all.

Parameters:
- NUM_PORTS, 2, number of upstream channels (≥2).
- ADDR_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, data width in bits; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- ch_read  in  NUM_PORTS  per-channel read request.
- ch_write  in  NUM_PORTS  per-channel write request.
- ch_byte_enable  in  NUM_PORTS*BE_WIDTH  per-channel byte enables, channel i at slice [i*BE_WIDTH +: BE_WIDTH].
- ch_address  in  NUM_PORTS*ADDR_WIDTH  per-channel address, packed the same way.
- ch_wdata  in  NUM_PORTS*DATA_WIDTH  per-channel write data, packed the same way.
- ch_resp  out  NUM_PORTS  one-hot completion pulse.
- ch_rdata  out  DATA_WIDTH  read data, broadcast to all channels.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_byte_enable  out  BE_WIDTH  downstream byte enables.
- mem_address  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  DATA_WIDTH  downstream write data.
- mem_resp  in  1  downstream completion.
- mem_rdata  in  DATA_WIDTH  downstream read data.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=0, grant=0.
  - Latched address/wdata/byte-enable=0.
  - mem_read=mem_write=0; ch_resp=0.
  - Reset mid-transaction abandons it; no ch_resp is issued.
- IDLE:
  - A channel is requesting when ch_read[i]|ch_write[i].
  - If any channel requests, pick the first requester at or after rr_ptr (modulo NUM_PORTS).
  - On the clock edge, register grant=i, op, address, wdata and byte enables, then go to BUSY.
  - With no request, stay in IDLE.
  - mem_resp is ignored in IDLE.
- BUSY:
  - mem_read/mem_write are driven from the latched op; mem_address/mem_wdata/mem_byte_enable are driven from the latched registers.
  - Downstream signals are stable for the whole transaction, even if the requester changes its inputs.
  - When mem_resp=1: ch_resp[grant]=1 in the same cycle (combinational) and ch_rdata=mem_rdata (combinational pass-through, valid whenever mem_resp=1).
  - On that edge: state→IDLE, rr_ptr=(grant+1) mod NUM_PORTS.
  - mem_read/mem_write drop in the cycle after resp.
- Latency:
  - Request seen in cycle t gives mem_read/mem_write high in cycle t+1.
  - One mandatory IDLE cycle separates back-to-back transactions.
  - The arbiter adds 1 cycle of overhead per transaction.
- Fairness: a channel waits at most NUM_PORTS-1 transactions before being granted.
- Write priority: ch_read[i] and ch_write[i] both high is illegal. The arbiter treats it as a write and a simulation assertion fires.
- Request withdrawn while granted: the downstream transaction still completes and ch_resp[grant] still pulses.
- Requester rule: a requester deasserts its request on the edge after its ch_resp. A request still high in IDLE is treated as a new request.
- ch_resp is never asserted for more than one channel and never in IDLE.

Decomposition:
- Shared package mem_arb_types:
  - arb_state_t enum {IDLE, BUSY}.
  - Op encoding {ARB_READ, ARB_WRITE}.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[NUM_PORTS], ptr.
  - Outputs: valid, idx [$clog2(NUM_PORTS)-1:0].
  - Implementation: doubled request vector rotated by ptr, then a find-first-set.

Test Plan:
- Single read: N=2, ch_read[0]=1, addr=0x0000_1000, memory returns 0xDEADBEEF after 3 cycles.
  - mem_read high from the next cycle, mem_address=0x1000.
  - ch_resp=2'b01 for one cycle with ch_rdata=0xDEADBEEF.
  - mem_read low the following cycle.
- Write path: ch_write[1]=1, addr=0x2004, wdata=0x12345678, be=4'b0011.
  - Downstream shows identical values with mem_write=1.
  - ch_resp=2'b10 on mem_resp.
- Contention, N=2: both channels request continuously from reset.
  - Grants alternate 0,1,0,1.
  - Each transaction is separated by exactly one IDLE cycle.
- Fairness, N=4: channels 0,2,3 request, rr_ptr=3.
  - Grant order 3,0,2.
  - Channel 1 is never granted.
- Stability and withdrawal: change ch_address[0] to 0xFFFF_FFFF mid-BUSY.
  - mem_address stays at the latched 0x1000.
  - Withdrawing ch_read[0] still yields ch_resp[0] on mem_resp.
- Async reset mid-BUSY: pull rst=0 between clock edges.
  - mem_read=0 immediately, no ch_resp.
  - After release, the first grant goes to channel 0 (rr_ptr=0).
